// File: rtl/apb_slave.sv
// APB4 completer front-end: captures the setup phase for a generic backend and
// holds the access phase with wait states until the backend reports completion.
module apb_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [ADDR_WIDTH-1:0]     paddr,
    input  logic [2:0]                pprot,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [BYTES_PER_WORD-1:0] pstrb,
    input  logic                      slave_data_valid,
    input  logic [DATA_WIDTH-1:0]     slave_read_data,
    input  logic                      slave_error,
    output logic [ADDR_WIDTH-1:0]     slave_address,
    output logic [2:0]                slave_protection,
    output logic                      slave_read_write,
    output logic [DATA_WIDTH-1:0]     slave_write_data,
    output logic [BYTES_PER_WORD-1:0] slave_strobe,
    output logic                      master_data_ready,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state;
    state_t state_next;
    logic   capture;

    // A setup phase is only honoured from IDLE; psel+penable there is a protocol violation.
    assign capture = (state == IDLE) && psel && !penable;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            slave_address    <= '0;
            slave_protection <= '0;
            slave_read_write <= 1'b0;
            slave_write_data <= '0;
            slave_strobe     <= '0;
        end else if (capture) begin
            slave_address    <= paddr;
            slave_protection <= pprot;
            slave_read_write <= pwrite;
            slave_write_data <= pwdata;
            slave_strobe     <= pwrite ? pstrb : '0;
        end
    end

    always_comb begin
        state_next        = state;
        master_data_ready = 1'b0;
        pready            = 1'b0;
        pslverr           = 1'b0;
        prdata            = '0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                master_data_ready = 1'b1;
                pready            = psel && penable && slave_data_valid;
                if (pready) begin
                    pslverr    = slave_error;
                    if (!slave_read_write) begin
                        prdata = slave_read_data;
                    end
                    state_next = IDLE;
                end else if (!psel) begin
                    // Master abandoned the transfer; drop it without a pready.
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: table of APB transfers with a prdata/pslverr
// scoreboard, plus hand-written reset, abort and protocol-violation sequences.
module tb_apb_slave;

    logic        pclk;
    logic        preset;
    logic [9:0]  paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        slave_data_valid;
    logic [31:0] slave_read_data;
    logic        slave_error;
    logic [9:0]  slave_address;
    logic [2:0]  slave_protection;
    logic        slave_read_write;
    logic [31:0] slave_write_data;
    logic [3:0]  slave_strobe;
    logic        master_data_ready;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    typedef struct {
        logic [9:0]  addr;
        logic [2:0]  prot;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } vec_t;

    typedef struct {
        logic [31:0] prdata;
        logic        pslverr;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    logic [9:0]  exp_addr;
    logic [2:0]  exp_prot;
    logic        exp_rw;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;

    int checks;
    int fails;

    apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .pclk              (pclk),
        .preset            (preset),
        .paddr             (paddr),
        .pprot             (pprot),
        .psel              (psel),
        .penable           (penable),
        .pwrite            (pwrite),
        .pwdata            (pwdata),
        .pstrb             (pstrb),
        .slave_data_valid  (slave_data_valid),
        .slave_read_data   (slave_read_data),
        .slave_error       (slave_error),
        .slave_address     (slave_address),
        .slave_protection  (slave_protection),
        .slave_read_write  (slave_read_write),
        .slave_write_data  (slave_write_data),
        .slave_strobe      (slave_strobe),
        .master_data_ready (master_data_ready),
        .pready            (pready),
        .prdata            (prdata),
        .pslverr           (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkLatched(input string name);
        checkOutput({name, "_addr"},  32'(slave_address),    32'(exp_addr));
        checkOutput({name, "_prot"},  32'(slave_protection), 32'(exp_prot));
        checkOutput({name, "_rw"},    32'(slave_read_write), 32'(exp_rw));
        checkOutput({name, "_wdata"}, slave_write_data,      exp_wdata);
        checkOutput({name, "_strb"},  32'(slave_strobe),     32'(exp_strb));
    endtask

    // Sample at the falling edge; any pready must match the oldest scoreboard entry.
    task automatic sampleCycle();
        exp_t e;
        @(negedge pclk);
        if (pready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_pready: got pready=1, expected no transfer pending (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_prdata",  prdata,        e.prdata);
                checkOutput("sb_pslverr", 32'(pslverr),  32'(e.pslverr));
            end
        end
    endtask

    task automatic driveSetup(input logic [9:0] a, input logic [2:0] p, input logic w,
                              input logic [31:0] d, input logic [3:0] s);
        @(posedge pclk); #1;
        psel             = 1'b1;
        penable          = 1'b0;
        paddr            = a;
        pprot            = p;
        pwrite           = w;
        pwdata           = d;
        pstrb            = s;
        slave_data_valid = 1'b0;
        slave_error      = 1'b0;
        slave_read_data  = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int   mdr_cycles;
        exp_t e;
        driveSetup(v.addr, v.prot, v.write, v.wdata, v.strb);
        e.prdata  = v.write ? 32'd0 : v.rdata;
        e.pslverr = v.err;
        sb.push_back(e);
        sampleCycle();
        checkOutput("setup_mdr",    32'(master_data_ready), 32'd0);
        checkOutput("setup_pready", 32'(pready),            32'd0);
        checkLatched("setup_hold");
        exp_addr  = v.addr;
        exp_prot  = v.prot;
        exp_rw    = v.write;
        exp_wdata = v.wdata;
        exp_strb  = v.write ? v.strb : 4'h0;
        mdr_cycles = 0;
        for (int w = 0; w <= v.waits; w++) begin
            @(posedge pclk); #1;
            penable = 1'b1;
            if (w == v.waits) begin
                slave_data_valid = 1'b1;
                slave_read_data  = v.rdata;
                slave_error      = v.err;
            end else begin
                slave_data_valid = 1'b0;
                slave_read_data  = $urandom;
                slave_error      = 1'($urandom_range(0, 1));
            end
            sampleCycle();
            if (master_data_ready === 1'b1) mdr_cycles++;
            checkOutput("access_pready", 32'(pready), (w == v.waits) ? 32'd1 : 32'd0);
            if (w == 0) checkLatched("capture");
            if (w != v.waits) begin
                checkOutput("wait_pslverr", 32'(pslverr), 32'd0);
                checkOutput("wait_prdata",  prdata,       32'd0);
            end
        end
        checkOutput("mdr_cycles", mdr_cycles, v.waits + 1);
    endtask

    task automatic goIdle();
        @(posedge pclk); #1;
        psel             = 1'b0;
        penable          = 1'b0;
        slave_data_valid = 1'b0;
        slave_error      = 1'b0;
    endtask

    initial begin
        vecs[0] = '{addr: 10'd122,  prot: 3'b110, write: 1'b1, wdata: 32'd2772003,  strb: 4'hF,
                    rdata: 32'h0BAD_F00D, err: 1'b1, waits: 4};
        vecs[1] = '{addr: 10'd125,  prot: 3'b100, write: 1'b0, wdata: 32'h1111_2222, strb: 4'hA,
                    rdata: 32'd2772003,   err: 1'b0, waits: 0};
        vecs[2] = '{addr: 10'd4,    prot: 3'b001, write: 1'b1, wdata: 32'hA5A5_0001, strb: 4'h3,
                    rdata: 32'h7777_7777, err: 1'b0, waits: 0};
        vecs[3] = '{addr: 10'd8,    prot: 3'b010, write: 1'b0, wdata: 32'h0000_0042, strb: 4'hF,
                    rdata: 32'hDEAD_BEEF, err: 1'b0, waits: 2};
        vecs[4] = '{addr: 10'd1023, prot: 3'b111, write: 1'b0, wdata: 32'hFFFF_FFFF, strb: 4'hC,
                    rdata: 32'hFFFF_FFFF, err: 1'b1, waits: 1};
        vecs[5] = '{addr: 10'd0,    prot: 3'b000, write: 1'b1, wdata: 32'h8000_0001, strb: 4'h0,
                    rdata: 32'h1234_5678, err: 1'b0, waits: 0};

        checks = 0;
        fails  = 0;
        preset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pprot = '0; pwdata = '0; pstrb = '0;
        slave_data_valid = 1'b0; slave_read_data = '0; slave_error = 1'b0;
        exp_addr = '0; exp_prot = '0; exp_rw = 1'b0; exp_wdata = '0; exp_strb = '0;

        $display("[TB] reset");
        repeat (2) begin
            @(posedge pclk); #1;
            sampleCycle();
        end
        checkOutput("reset_mdr",     32'(master_data_ready), 32'd0);
        checkOutput("reset_pready",  32'(pready),            32'd0);
        checkOutput("reset_prdata",  prdata,                 32'd0);
        checkOutput("reset_pslverr", 32'(pslverr),           32'd0);
        checkLatched("reset");
        @(posedge pclk); #1;
        preset = 1'b0;

        $display("[TB] table-driven transfers, back-to-back");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end
        goIdle();
        sampleCycle();
        checkOutput("idle_mdr", 32'(master_data_ready), 32'd0);
        checkLatched("post_table_hold");

        $display("[TB] reset during access wait");
        driveSetup(10'd300, 3'b011, 1'b1, 32'h0000_1234, 4'h5);
        sampleCycle();
        exp_addr = 10'd300; exp_prot = 3'b011; exp_rw = 1'b1; exp_wdata = 32'h0000_1234; exp_strb = 4'h5;
        @(posedge pclk); #1;
        penable = 1'b1;
        sampleCycle();
        checkOutput("rst_wait_mdr", 32'(master_data_ready), 32'd1);
        checkLatched("rst_capture");
        @(posedge pclk); #1;
        preset = 1'b1;
        sampleCycle();
        @(posedge pclk); #1;
        preset = 1'b0;
        psel = 1'b0; penable = 1'b0;
        sampleCycle();
        exp_addr = '0; exp_prot = '0; exp_rw = 1'b0; exp_wdata = '0; exp_strb = '0;
        checkOutput("rst_mid_mdr",     32'(master_data_ready), 32'd0);
        checkOutput("rst_mid_pready",  32'(pready),            32'd0);
        checkOutput("rst_mid_prdata",  prdata,                 32'd0);
        checkOutput("rst_mid_pslverr", 32'(pslverr),           32'd0);
        checkLatched("rst_mid");

        $display("[TB] abort by dropping psel");
        driveSetup(10'd50, 3'b001, 1'b0, 32'h0000_0050, 4'hF);
        sampleCycle();
        exp_addr = 10'd50; exp_prot = 3'b001; exp_rw = 1'b0; exp_wdata = 32'h0000_0050; exp_strb = 4'h0;
        @(posedge pclk); #1;
        penable = 1'b1;
        sampleCycle();
        checkOutput("abort_wait_mdr", 32'(master_data_ready), 32'd1);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        slave_data_valid = 1'b1; slave_read_data = 32'hCAFE_CAFE;
        sampleCycle();
        checkOutput("abort_pready", 32'(pready), 32'd0);
        @(posedge pclk); #1;
        sampleCycle();
        checkOutput("abort_mdr_fall", 32'(master_data_ready), 32'd0);
        checkOutput("abort_after_pready", 32'(pready), 32'd0);

        $display("[TB] protocol violation from idle");
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 10'd777; pprot = 3'b101; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        slave_data_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sampleCycle();
            checkOutput("viol_mdr",    32'(master_data_ready), 32'd0);
            checkOutput("viol_pready", 32'(pready),            32'd0);
            @(posedge pclk); #1;
        end
        checkLatched("viol_hold");
        goIdle();

        $display("[TB] recovery transfer");
        applyStimulus(vecs[0]);
        goIdle();
        sampleCycle();
        checkOutput("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
